// File: rtl/vc_input_unit.sv
// Router input stage: demuxes flits into two per-VC FIFOs, computes XY routes from head flits,
// tracks wormhole packet state per VC and returns one registered credit per dequeued flit.
module vc_input_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned MY_X   = 0,
  parameter int unsigned MY_Y   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ivalid,
  input  logic [DATA_W-1:0] idata,
  input  logic              ivch,
  input  logic [1:0]        grt,
  input  logic              oready,
  output logic              ovalid0,
  output logic              ovalid1,
  output logic [DATA_W-1:0] odata0,
  output logic [DATA_W-1:0] odata1,
  output logic              ovch0,
  output logic              ovch1,
  output logic              req0,
  output logic              req1,
  output logic [4:0]        port0,
  output logic [4:0]        port1,
  output logic [1:0]        ocredit,
  output logic              err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [3:0]  LOC_X = 4'(MY_X);
  localparam logic [3:0]  LOC_Y = 4'(MY_Y);

  typedef enum logic {StIdle, StOpen} pkt_state_e;

  logic [DATA_W-1:0] r_mem    [2][DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr [2];
  logic [PTR_W-1:0]  r_wr_ptr [2];
  logic [CNT_W-1:0]  r_count  [2];
  pkt_state_e        r_state  [2];
  logic [4:0]        r_route  [2];
  logic [1:0]        r_credit;
  logic              r_err;

  pkt_state_e        w_state_nxt [2];
  logic [4:0]        w_route_nxt [2];
  logic [DATA_W-1:0] w_head [2];
  logic [1:0]        w_type [2];
  logic [4:0]        w_calc [2];
  logic [4:0]        w_port [2];
  logic [1:0]        w_empty, w_full, w_pop, w_push, w_drop, w_hit;

  // {L,W,S,E,N}: X is resolved before Y
  function automatic logic [4:0] xy_route(input logic [3:0] dx, input logic [3:0] dy);
    if (dx > LOC_X)      return 5'b00010;
    else if (dx < LOC_X) return 5'b01000;
    else if (dy > LOC_Y) return 5'b00100;
    else if (dy < LOC_Y) return 5'b00001;
    else                 return 5'b10000;
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_empty[i] = (r_count[i] == '0);
      w_full[i]  = (r_count[i] == CNT_W'(DEPTH));
      w_head[i]  = w_empty[i] ? '0 : r_mem[i][r_rd_ptr[i]];
      w_type[i]  = w_head[i][DATA_W-1 -: 2];
      w_calc[i]  = xy_route(w_head[i][7:4], w_head[i][3:0]);
      w_pop[i]   = grt[i] & oready & ~w_empty[i];
      w_hit[i]   = ivalid & (ivch == i[0]);
      // A pop in the same cycle frees the slot a full FIFO needs
      w_push[i]  = w_hit[i] & (~w_full[i] | w_pop[i]);
      w_drop[i]  = w_hit[i] & w_full[i] & ~w_pop[i];
      // Open packets keep their route across bubbles so the VC mux grant stays stable
      if (w_empty[i])        w_port[i] = (r_state[i] == StOpen) ? r_route[i] : '0;
      else if (w_type[i][0]) w_port[i] = w_calc[i];
      else                   w_port[i] = r_route[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_state_nxt[i] = r_state[i];
      w_route_nxt[i] = r_route[i];
      if (w_pop[i]) begin
        case (r_state[i])
          StIdle: begin
            if (w_type[i] == 2'b01) begin
              w_state_nxt[i] = StOpen;
              w_route_nxt[i] = w_calc[i];
            end
          end
          StOpen: begin
            if (w_type[i] == 2'b10) w_state_nxt[i] = StIdle;
          end
          default: w_state_nxt[i] = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= idata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_rd_ptr[i] <= '0;
        r_wr_ptr[i] <= '0;
        r_count[i]  <= '0;
        r_state[i]  <= StIdle;
        r_route[i]  <= '0;
      end
      r_credit <= '0;
      r_err    <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
        if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
        case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
          2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
          default: ;
        endcase
        r_state[i] <= w_state_nxt[i];
        r_route[i] <= w_route_nxt[i];
      end
      r_credit <= w_pop;
      r_err    <= r_err | (|w_drop);
    end
  end

  assign ovalid0 = ~w_empty[0];
  assign ovalid1 = ~w_empty[1];
  assign odata0  = w_head[0];
  assign odata1  = w_head[1];
  assign ovch0   = 1'b0;
  assign ovch1   = 1'b1;
  assign req0    = ~w_empty[0] | (r_state[0] == StOpen);
  assign req1    = ~w_empty[1] | (r_state[1] == StOpen);
  assign port0   = w_port[0];
  assign port1   = w_port[1];
  assign ocredit = r_credit;
  assign err     = r_err;

endmodule

// File: tb/tb_vc_input_unit.sv
// Randomised scoreboard bench for vc_input_unit: the driver queues accepted flits per VC,
// a negedge monitor compares every DUT output against queue contents and packet-level state.
module tb_vc_input_unit;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int MX    = 2;
  localparam int MY    = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ivalid = 1'b0;
  logic [DW-1:0] idata = '0;
  logic          ivch = 1'b0;
  logic [1:0]    grt = '0;
  logic          oready = 1'b0;
  logic          ovalid0, ovalid1, ovch0, ovch1, req0, req1, err;
  logic [DW-1:0] odata0, odata1;
  logic [4:0]    port0, port1;
  logic [1:0]    ocredit;

  logic          d_ovalid [2];
  logic [DW-1:0] d_odata  [2];
  logic          d_req    [2];
  logic [4:0]    d_port   [2];

  assign d_ovalid[0] = ovalid0;
  assign d_ovalid[1] = ovalid1;
  assign d_odata[0]  = odata0;
  assign d_odata[1]  = odata1;
  assign d_req[0]    = req0;
  assign d_req[1]    = req1;
  assign d_port[0]   = port0;
  assign d_port[1]   = port1;

  vc_input_unit #(.DATA_W(DW), .DEPTH(DEPTH), .MY_X(MX), .MY_Y(MY)) dut (
    .clk(clk), .rst(rst), .ivalid(ivalid), .idata(idata), .ivch(ivch), .grt(grt),
    .oready(oready), .ovalid0(ovalid0), .ovalid1(ovalid1), .odata0(odata0), .odata1(odata1),
    .ovch0(ovch0), .ovch1(ovch1), .req0(req0), .req1(req1), .port0(port0), .port1(port1),
    .ocredit(ocredit), .err(err)
  );

  always #5 clk = ~clk;

  // Reference state: flits held per VC, packet open flag and latched route, sticky error.
  logic [DW-1:0] exp_q [2][$];
  logic          m_open [2];
  logic [4:0]    m_route [2];
  logic          m_pop_prev [2];
  logic          m_err = 1'b0;
  logic          pend_v = 1'b0;
  logic          pend_vc = 1'b0;
  logic          drop_now = 1'b0;
  logic          mon_en = 1'b0;
  int            tests = 0;
  int            failed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_route(input logic [DW-1:0] f);
    int dx, dy;
    dx = int'(f[7:4]);
    dy = int'(f[3:0]);
    if (dx > MX) return 5'b00010;
    if (dx < MX) return 5'b01000;
    if (dy > MY) return 5'b00100;
    if (dy < MY) return 5'b00001;
    return 5'b10000;
  endfunction

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input int dx, input int dy);
    logic [DW-1:0] f;
    f = $urandom;
    f[DW-1:DW-2] = t;
    f[7:4] = 4'(dx);
    f[3:0] = 4'(dy);
    return f;
  endfunction

  function automatic logic [DW-1:0] rand_flit();
    return mk(2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3));
  endfunction

  // Called just after a posedge; sets inputs for the next edge and records what it will accept.
  task automatic drive(input logic v, input logic [DW-1:0] f, input logic vc,
                       input logic [1:0] g, input logic r);
    int   sz;
    logic popn;
    ivalid = v;
    idata  = f;
    ivch   = vc;
    grt    = g;
    oready = r;
    if (v) begin
      sz   = exp_q[vc].size();
      popn = g[vc] & r & (sz > 0);
      if (sz < DEPTH || popn) begin
        exp_q[vc].push_back(f);
        pend_v  = 1'b1;
        pend_vc = vc;
      end else begin
        drop_now = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " ovalid0"}, 64'(ovalid0), 64'd0);
    chk({tag, " ovalid1"}, 64'(ovalid1), 64'd0);
    chk({tag, " odata0"}, 64'(odata0), 64'd0);
    chk({tag, " odata1"}, 64'(odata1), 64'd0);
    chk({tag, " req0"}, 64'(req0), 64'd0);
    chk({tag, " req1"}, 64'(req1), 64'd0);
    chk({tag, " port0"}, 64'(port0), 64'd0);
    chk({tag, " port1"}, 64'(port1), 64'd0);
    chk({tag, " ocredit"}, 64'(ocredit), 64'd0);
    chk({tag, " err"}, 64'(err), 64'd0);
  endtask

  // Grant and oready are held high during reset: reset must still suppress pops and credits.
  task automatic do_reset(input string tag);
    mon_en = 1'b0;
    rst    = 1'b1;
    ivalid = 1'b0;
    grt    = 2'b01;
    oready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      m_open[i]     = 1'b0;
      m_route[i]    = '0;
      m_pop_prev[i] = 1'b0;
    end
    m_err = 1'b0;
    pend_v = 1'b0;
    drop_now = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero({tag, "/1"});
    @(posedge clk);
    @(negedge clk);
    check_zero({tag, "/2"});
    rst    = 1'b0;
    grt    = '0;
    oready = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        int            eff;
        logic [DW-1:0] hd;
        logic [4:0]    ep;
        logic          pop;
        eff = exp_q[i].size() - ((pend_v && pend_vc == i[0]) ? 1 : 0);
        hd  = (eff > 0) ? exp_q[i][0] : '0;
        if (eff == 0)       ep = m_open[i] ? m_route[i] : 5'b0;
        else if (hd[DW-2])  ep = ref_route(hd);
        else                ep = m_route[i];
        chk($sformatf("ovalid%0d", i), 64'(d_ovalid[i]), 64'(eff > 0));
        chk($sformatf("odata%0d", i), 64'(d_odata[i]), 64'(hd));
        chk($sformatf("req%0d", i), 64'(d_req[i]), 64'((eff > 0) | m_open[i]));
        chk($sformatf("port%0d", i), 64'(d_port[i]), 64'(ep));
        chk($sformatf("ocredit%0d", i), 64'(ocredit[i]), 64'(m_pop_prev[i]));
        pop = grt[i] & oready & (eff > 0);
        if (pop) begin
          if (!m_open[i] && hd[DW-1:DW-2] == 2'b01) begin
            m_open[i]  = 1'b1;
            m_route[i] = ref_route(hd);
          end else if (m_open[i] && hd[DW-1:DW-2] == 2'b10) begin
            m_open[i] = 1'b0;
          end
          void'(exp_q[i].pop_front());
        end
        m_pop_prev[i] = pop;
      end
      chk("ovch", 64'({ovch1, ovch0}), 64'(2'b10));
      chk("err", 64'(err), 64'(m_err));
      if (drop_now) m_err = 1'b1;
      drop_now = 1'b0;
      pend_v   = 1'b0;
    end
  end

  task automatic run_phase(input int n, input int pv, input int pg, input bit alt);
    for (int c = 0; c < n; c++) begin
      logic       v;
      logic       vc;
      logic [1:0] g;
      logic       r;
      v  = ($urandom_range(0, 99) < pv);
      vc = alt ? c[0] : 1'($urandom_range(0, 1));
      if (alt)                             g = c[0] ? 2'b01 : 2'b10;
      else if ($urandom_range(0, 99) < pg) g = $urandom_range(0, 1) ? 2'b01 : 2'b10;
      else                                 g = 2'b00;
      r  = alt ? 1'b1 : ($urandom_range(0, 99) < 80);
      drive(v, rand_flit(), vc, g, r);
    end
  endtask

  initial begin
    do_reset("reset");

    // Full VC0, then a 5th flit with a same-cycle pop (accepted) and one without (dropped).
    drive(1'b1, mk(2'b01, 3, 0), 1'b0, 2'b00, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b1, mk(2'b00, 0, 0), 1'b0, 2'b00, 1'b0);
    drive(1'b1, mk(2'b10, 0, 0), 1'b0, 2'b01, 1'b1);
    chk("err after full+pop", 64'(err), 64'd0);
    drive(1'b1, mk(2'b00, 0, 0), 1'b0, 2'b00, 1'b0);
    chk("err after overflow", 64'(err), 64'd1);
    for (int k = 0; k < 6; k++) drive(1'b0, '0, 1'b0, 2'b01, 1'b1);

    // Head+tail addressed to this router goes local and leaves no packet open.
    drive(1'b1, mk(2'b11, MX, MY), 1'b1, 2'b00, 1'b0);
    chk("ht port1 local", 64'(port1), 64'(5'b10000));
    drive(1'b0, '0, 1'b0, 2'b10, 1'b1);
    drive(1'b0, '0, 1'b0, 2'b00, 1'b0);
    chk("ht req1 after pop", 64'(req1), 64'd0);

    // Wormhole with a bubble between body and tail.
    drive(1'b1, mk(2'b01, 0, 1), 1'b1, 2'b00, 1'b0);
    drive(1'b1, mk(2'b00, 0, 0), 1'b1, 2'b10, 1'b1);
    drive(1'b0, '0, 1'b0, 2'b10, 1'b1);
    drive(1'b0, '0, 1'b0, 2'b10, 1'b1);
    chk("bubble req1", 64'(req1), 64'd1);
    chk("bubble port1", 64'(port1), 64'(5'b01000));
    drive(1'b1, mk(2'b10, 0, 0), 1'b1, 2'b10, 1'b1);
    for (int k = 0; k < 3; k++) drive(1'b0, '0, 1'b0, 2'b10, 1'b1);

    run_phase(200, 90, 10, 1'b0);
    do_reset("reset2");
    run_phase(400, 60, 70, 1'b0);
    do_reset("reset3");
    run_phase(300, 100, 0, 1'b1);
    run_phase(200, 50, 50, 1'b0);

    // Reset while VC0 holds an open packet with three flits buffered.
    do_reset("reset4");
    drive(1'b1, mk(2'b01, 3, 1), 1'b0, 2'b00, 1'b0);
    drive(1'b1, mk(2'b00, 0, 0), 1'b0, 2'b01, 1'b1);
    drive(1'b1, mk(2'b00, 0, 0), 1'b0, 2'b00, 1'b0);
    drive(1'b1, mk(2'b00, 0, 0), 1'b0, 2'b00, 1'b0);
    chk("open req0", 64'(req0), 64'd1);
    chk("open port0", 64'(port0), 64'(5'b00010));
    do_reset("midpkt");
    drive(1'b0, '0, 1'b0, 2'b00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
